sram_frame_loader: RTL and testbench

//  Load stage between uart_rx and sram_ctrl. Packs received UART bytes into 16-bit words and buffers them
//  in a 4-deep word FIFO. Writes the words to consecutive SRAM addresses from 0, then flags completion
//  so the top FSM can leave LOAD. Drives the sram_ctrl selec/write/read/data/addr set and a word count
//  for the seven-segment display.

---
 rtl/sram_frame_loader.sv | 183 ++++++++++++++++++
 tb/tb_sram_frame_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_loader.sv
`timescale 1ns/1ps
// sram_frame_loader
// Packs UART bytes (low byte first) into 16-bit words, buffers them in a
// 4-deep FIFO and writes them to consecutive SRAM word addresses from 0
// through the sram_ctrl handshake. Sets finish once TOTAL_WORDS are written.
// Optional feature macro: LOADER_CHECKSUM_EN (running 16-bit sum of words).
module sram_frame_loader #(
  parameter int unsigned TOTAL_WORDS = 524288,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned WR_HOLD     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [7:0]        data_i,
  input  logic              receive_ack,
  output logic              sram_write_selec,
  output logic              sram_write_write,
  output logic              sram_write_read,
  output logic [15:0]       sram_write_data,
  output logic [ADDR_W-1:0] sram_write_addr,
  output logic              sram_write_finish,
  output logic [19:0]       sram_write_count,
  output logic              overflow,
  output logic [15:0]       checksum
);

  localparam int unsigned      HOLD_W    = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);
  localparam logic [20:0]       TOTAL     = 21'(TOTAL_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_RELEASE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                have_lo_q;
  logic [7:0]          lo_q;

  logic [15:0]         mem_q [4];
  logic [1:0]          wr_ptr_q, rd_ptr_q;
  logic [2:0]          fill_q;
  logic                overflow_q;

  logic [15:0]         data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [19:0]         count_q;

  logic                accept, push, do_push, pop, word_done, last_word;
  logic                fifo_empty, fifo_full;

  assign fifo_empty = (fill_q == 3'd0);
  assign fifo_full  = (fill_q == 3'd4);
  assign accept     = load_start && receive_ack && (state_q != S_DONE);
  assign push       = accept && have_lo_q;
  // A pop on the same edge frees the slot, so a full FIFO still takes the word.
  assign do_push    = push && (!fifo_full || pop);
  assign last_word  = (({1'b0, count_q} + 21'd1) == TOTAL);

  // Write FSM next-state, pop request and word-completion pulse.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pop       = 1'b0;
    word_done = 1'b0;
    if (!load_start) begin
      state_d = S_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          state_d = S_STROBE;
          hold_d  = '0;
        end
        S_STROBE: begin
          if (hold_q == HOLD_LAST) state_d = S_RELEASE;
          else                     hold_d  = hold_q + 1'b1;
        end
        S_RELEASE: begin
          word_done = 1'b1;
          state_d   = last_word ? S_DONE : S_WAIT;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state and strobe-hold counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Byte packer: first byte held as low half, second byte completes the word.
  always_ff @(posedge clk) begin
    if (!rst_n || !load_start) begin
      have_lo_q <= 1'b0;
      lo_q      <= '0;
    end else if (accept) begin
      if (have_lo_q) begin
        have_lo_q <= 1'b0;
      end else begin
        have_lo_q <= 1'b1;
        lo_q      <= data_i;
      end
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {data_i, lo_q};
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n || !load_start) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      fill_q <= fill_q + {2'b00, do_push} - {2'b00, pop};
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // Write datapath: word latched on pop, address/count advance after RELEASE.
  always_ff @(posedge clk) begin
    if (!rst_n || !load_start) begin
      data_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) data_q <= mem_q[rd_ptr_q];
      if (word_done) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 20'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Running modulo-2^16 sum of every word written.
  always_ff @(posedge clk) begin
    if (!rst_n || !load_start) checksum_q <= '0;
    else if (word_done)        checksum_q <= checksum_q + data_q;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign sram_write_selec  = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                             (state_q == S_RELEASE);
  assign sram_write_write  = (state_q == S_STROBE);
  assign sram_write_read   = 1'b0;
  assign sram_write_finish = (state_q == S_DONE);
  assign sram_write_data   = data_q;
  assign sram_write_addr   = addr_q;
  assign sram_write_count  = count_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_sram_frame_loader.sv
`timescale 1ns/1ps
// Directed bench for sram_frame_loader: two instances, one small frame with
// short strobes (A) and one with long strobes to force FIFO overflow (B).
module tb_sram_frame_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ls_a = 1'b0, ack_a = 1'b0;
  logic [7:0]  d_a = '0;
  logic        selec_a, write_a, read_a, finish_a, ovf_a;
  logic [15:0] data_a, csum_a;
  logic [18:0] addr_a;
  logic [19:0] cnt_a;

  logic        ls_b = 1'b0, ack_b = 1'b0;
  logic [7:0]  d_b = '0;
  logic        selec_b, write_b, read_b, finish_b, ovf_b;
  logic [15:0] data_b, csum_b;
  logic [18:0] addr_b;
  logic [19:0] cnt_b;

  sram_frame_loader #(.TOTAL_WORDS(2), .ADDR_W(19), .WR_HOLD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_start(ls_a), .data_i(d_a), .receive_ack(ack_a),
    .sram_write_selec(selec_a), .sram_write_write(write_a), .sram_write_read(read_a),
    .sram_write_data(data_a), .sram_write_addr(addr_a), .sram_write_finish(finish_a),
    .sram_write_count(cnt_a), .overflow(ovf_a), .checksum(csum_a)
  );

  sram_frame_loader #(.TOTAL_WORDS(8), .ADDR_W(19), .WR_HOLD(40)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_start(ls_b), .data_i(d_b), .receive_ack(ack_b),
    .sram_write_selec(selec_b), .sram_write_write(write_b), .sram_write_read(read_b),
    .sram_write_data(data_b), .sram_write_addr(addr_b), .sram_write_finish(finish_b),
    .sram_write_count(cnt_b), .overflow(ovf_b), .checksum(csum_b)
  );

  // Record each write burst (rising edge of write) as seen by the SRAM side.
  logic [15:0] wd_a[$], wd_b[$];
  logic [18:0] wa_a[$], wa_b[$];
  logic        wprev_a = 1'b0, wprev_b = 1'b0;
  always @(negedge clk) begin
    if (write_a && !wprev_a) begin wd_a.push_back(data_a); wa_a.push_back(addr_a); end
    if (write_b && !wprev_b) begin wd_b.push_back(data_b); wa_b.push_back(addr_b); end
    wprev_a = write_a;
    wprev_b = write_b;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b, input int unsigned gap);
    d_a = b; ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_cnt_a(input string tag, input logic [19:0] target, input int unsigned budget);
    int unsigned i = 0;
    while (cnt_a != target && i < budget) begin tick(); i++; end
    check(tag, 32'(cnt_a), 32'(target));
  endtask

  task automatic clear_a();
    wd_a.delete(); wa_a.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_selec",  32'(selec_a),  32'h0);
    check("rst_write",  32'(write_a),  32'h0);
    check("rst_finish", 32'(finish_a), 32'h0);
    check("rst_count",  32'(cnt_a),    32'h0);
    check("rst_data",   32'(data_a),   32'h0);
    check("rst_ovf_b",  32'(ovf_b),    32'h0);
    rst_n = 1'b1;
    tick();

    // Overflow: 12 back-to-back bytes while the writer is stalled on long strobes
    ls_b = 1'b1;
    tick(); tick();
    for (int i = 0; i < 12; i++) begin
      d_b = 8'h10 + 8'(i); ack_b = 1'b1;
      tick();
    end
    ack_b = 1'b0;
    check("ovf_set", 32'(ovf_b), 32'h1);
    begin
      int unsigned k = 0;
      while (cnt_b != 20'd5 && k < 400) begin tick(); k++; end
    end
    repeat (100) tick();
    check("ovf_count5",   32'(cnt_b),        32'd5);
    check("ovf_nwrites",  32'(wd_b.size()),  32'd5);
    check("ovf_first",    32'(wd_b[0]),      32'h1110);
    check("ovf_last",     32'(wd_b[4]),      32'h1918);
    check("ovf_last_adr", 32'(wa_b[4]),      32'd4);
    check("ovf_sticky",   32'(ovf_b),        32'h1);
    check("ovf_nofinish", 32'(finish_b),     32'h0);
    check("ovf_read0",    32'(read_b),       32'h0);

    // Latency of one word (WR_HOLD=2), then complete a two-word frame
    ls_a = 1'b1;
    tick(); tick();
    send_a(8'h11, 6);
    send_a(8'h22, 0);                       // ack was in cycle 0; now cycle 1
    check("lat_c1_selec", 32'(selec_a), 32'h0);
    tick();                                 // cycle 2: SETUP
    check("lat_c2_selec", 32'(selec_a), 32'h1);
    check("lat_c2_write", 32'(write_a), 32'h0);
    check("lat_c2_data",  32'(data_a),  32'h2211);
    check("lat_c2_addr",  32'(addr_a),  32'h0);
    tick();
    check("lat_c3_write", 32'(write_a), 32'h1);
    tick();
    check("lat_c4_write", 32'(write_a), 32'h1);
    tick();
    check("lat_c5_write", 32'(write_a), 32'h0);
    check("lat_c5_selec", 32'(selec_a), 32'h1);
    check("lat_c5_count", 32'(cnt_a),   32'h0);
    tick();
    check("lat_c6_selec", 32'(selec_a), 32'h0);
    check("lat_c6_count", 32'(cnt_a),   32'h1);
    send_a(8'h33, 6);
    send_a(8'h44, 0);
    wait_cnt_a("frame_count", 20'd2, 50);
    check("frame_finish", 32'(finish_a),    32'h1);
    check("frame_nwr",    32'(wd_a.size()), 32'd2);
    check("frame_w0",     32'(wd_a[0]),     32'h2211);
    check("frame_a0",     32'(wa_a[0]),     32'h0);
    check("frame_w1",     32'(wd_a[1]),     32'h4433);
    check("frame_a1",     32'(wa_a[1]),     32'h1);
    check("frame_ovf",    32'(ovf_a),       32'h0);
    check("done_selec",   32'(selec_a),     32'h0);
    send_a(8'h55, 2);
    send_a(8'h66, 8);
    check("done_ignore",  32'(cnt_a),       32'd2);
    check("done_noovf",   32'(ovf_a),       32'h0);
    check("done_hold",    32'(finish_a),    32'h1);

    // Checksum over FFFF + 0002
    ls_a = 1'b0;
    tick();
    check("abort_count",  32'(cnt_a),    32'h0);
    check("abort_finish", 32'(finish_a), 32'h0);
    ls_a = 1'b1;
    tick();
    send_a(8'hFF, 8); send_a(8'hFF, 8); send_a(8'h02, 8); send_a(8'h00, 0);
    wait_cnt_a("csum_count", 20'd2, 50);
    check("csum_data", 32'(data_a), 32'h0002);
`ifdef LOADER_CHECKSUM_EN
    check("csum_value", 32'(csum_a), 32'h0001);
`else
    check("csum_value", 32'(csum_a), 32'h0000);
`endif

    // Abort with a partial byte pending
    ls_a = 1'b0; tick(); ls_a = 1'b1; tick();
    send_a(8'h11, 8); send_a(8'h22, 8); send_a(8'h33, 8);
    ls_a = 1'b0;
    tick();
    check("part_count0", 32'(cnt_a), 32'h0);
    clear_a();
    ls_a = 1'b1;
    tick();
    send_a(8'hAA, 8); send_a(8'hBB, 0);
    wait_cnt_a("part_count1", 20'd1, 20);
    check("part_nwr",  32'(wd_a.size()), 32'd1);
    check("part_data", 32'(wd_a[0]),     32'hBBAA);
    check("part_addr", 32'(wa_a[0]),     32'h0);

    // Reset asserted in the middle of STROBE
    send_a(8'hCC, 8); send_a(8'hDD, 0);
    tick(); tick();
    check("rs_strobe", 32'(write_a), 32'h1);
    rst_n = 1'b0;
    tick();
    check("rs_selec",  32'(selec_a),  32'h0);
    check("rs_write",  32'(write_a),  32'h0);
    check("rs_read",   32'(read_a),   32'h0);
    check("rs_data",   32'(data_a),   32'h0);
    check("rs_addr",   32'(addr_a),   32'h0);
    check("rs_finish", 32'(finish_a), 32'h0);
    check("rs_count",  32'(cnt_a),    32'h0);
    check("rs_ovf",    32'(ovf_a),    32'h0);
    check("rs_csum",   32'(csum_a),   32'h0);
    rst_n = 1'b1;
    tick();
    clear_a();
    send_a(8'h01, 8); send_a(8'h02, 0);
    wait_cnt_a("rl_count", 20'd1, 20);
    check("rl_nwr",  32'(wd_a.size()), 32'd1);
    check("rl_data", 32'(wd_a[0]),     32'h0201);
    check("rl_addr", 32'(wa_a[0]),     32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
